sysid_check_master: RTL and testbench

// - Avalon-MM read master that interrogates the system-ID slave (ID word at offset 0, timestamp word at offset 4).
// - Compares both words against expected values and reports pass/fail/timeout to the Ethernet system control logic.
// - Runs once after reset, or again on a start pulse; guards against an FPGA image that does not match the software build.

---
 rtl/ethsys_pkg.sv | 16 +
 rtl/avm_single_read.sv | 61 ++++++
 rtl/sysid_check_master.sv | 156 +++++++++++++++
 tb/tb_sysid_check_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ethsys_pkg.sv
// Shared definitions for the Ethernet system control logic:
// Avalon data width, sysid register offsets and the sysid checker FSM states.
package ethsys_pkg;

  localparam int AVALON_DATA_W = 32;
  localparam int SYSID_ID_OFS  = 0;
  localparam int SYSID_TS_OFS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_FINISH
  } sysid_state_e;

endpackage

// File: rtl/avm_single_read.sv
// One Avalon-MM read handshake with a waitrequest timeout.
// Completion (ok) and abort (to) are single-cycle strobes in the cycle the read ends.
module avm_single_read
  import ethsys_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     go,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     avm_read,
  output logic [ADDR_W-1:0]        avm_address,
  input  logic                     avm_waitrequest,
  input  logic [AVALON_DATA_W-1:0] avm_readdata,
  output logic [AVALON_DATA_W-1:0] rdata,
  output logic                     ok,
  output logic                     to
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       timer_q, timer_d;

  always_comb begin
    ok      = read_q & ~avm_waitrequest;
    to      = read_q & avm_waitrequest & (timer_q == TIMER_LAST);
    read_d  = read_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    if (read_q) begin
      if (avm_waitrequest) timer_d = timer_q + 16'd1;
      if (ok || to) read_d = 1'b0;
    end else if (go) begin
      read_d  = 1'b1;
      addr_d  = addr;
      timer_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      addr_q  <= '0;
      timer_q <= '0;
    end else begin
      read_q  <= read_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
    end
  end

  // Between reads the address follows the requester so it can settle in the gap.
  assign avm_read    = read_q;
  assign avm_address = read_q ? addr_q : addr;
  assign rdata       = avm_readdata;

endmodule

// File: rtl/sysid_check_master.sv
// Reads the sysid ID and timestamp words over Avalon-MM and reports whether
// they match the values this software build expects.
module sysid_check_master
  import ethsys_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [31:0]       EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0]       EXPECTED_TS = 32'h534C_DDA5,
  parameter int                TIMEOUT_CYC = 255,
  parameter bit                AUTO_START  = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam logic [ADDR_W-1:0] ID_ADDR = BASE_ADDR + ADDR_W'(SYSID_ID_OFS);
  localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(SYSID_TS_OFS);

  sysid_state_e state_q, state_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic [31:0]  id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic         auto_q, auto_d, issue_ts_q, issue_ts_d, ts_sel_q, ts_sel_d;

  logic                     launch, rd_go, rd_ok, rd_to;
  logic [ADDR_W-1:0]        rd_addr;
  logic [AVALON_DATA_W-1:0] rd_data;

  // busy stays high through the done cycle, so a start coincident with done is dropped.
  assign launch  = (state_q == ST_IDLE) & ~busy_q & (start | auto_q);
  assign rd_go   = launch | issue_ts_q;
  assign rd_addr = ts_sel_q ? TS_ADDR : ID_ADDR;

  avm_single_read #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_read (
    .clock           (clock),
    .reset_n         (reset_n),
    .go              (rd_go),
    .addr            (rd_addr),
    .avm_read        (avm_read),
    .avm_address     (avm_address),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .rdata           (rd_data),
    .ok              (rd_ok),
    .to              (rd_to)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    auto_d     = auto_q;
    issue_ts_d = 1'b0;
    ts_sel_d   = ts_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_RD_ID;
          busy_d    = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          auto_d    = 1'b0;
        end else if (busy_q) begin
          busy_d = 1'b0;
        end
      end
      ST_RD_ID: begin
        if (rd_ok) begin
          id_value_d = rd_data;
          id_ok_d    = (rd_data == EXPECTED_ID);
          issue_ts_d = 1'b1;
          ts_sel_d   = 1'b1;
          state_d    = ST_RD_TS;
        end else if (rd_to) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end
      ST_RD_TS: begin
        if (rd_ok) begin
          ts_value_d = rd_data;
          ts_ok_d    = (rd_data == EXPECTED_TS);
          state_d    = ST_FINISH;
        end else if (rd_to) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d   = 1'b1;
        ts_sel_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      auto_q     <= AUTO_START;
      issue_ts_q <= 1'b0;
      ts_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      auto_q     <= auto_d;
      issue_ts_q <= issue_ts_d;
      ts_sel_q   <= ts_sel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized self-checking bench for sysid_check_master: a responsive Avalon slave
// plus a cycle-count reference model derived from stall counts and data words.
module tb_sysid_check_master;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h534C_DDA5;
  localparam int          TO     = 8;
  localparam int          STUCK  = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [31:0] avm_address;
  logic        avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int check_count = 0;
  int pass_count  = 0;

  int          stall_id = 0;
  int          stall_ts = 0;
  logic [31:0] id_data  = EXP_ID;
  logic [31:0] ts_data  = EXP_TS;
  logic [31:0] exp_id_value = '0;
  logic [31:0] exp_ts_value = '0;

  sysid_check_master #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .TIMEOUT_CYC (TO),
    .AUTO_START  (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stalls each read by its configured count, returns data by address, noise otherwise.
  initial begin : slave
    int cnt;
    int lim;
    cnt = 0;
    forever begin
      @(negedge clock);
      avm_readdata = $urandom;
      if (!reset_n || !avm_read) begin
        avm_waitrequest = 1'b0;
        cnt = 0;
      end else begin
        lim = (avm_address == BASE) ? stall_id : stall_ts;
        if (cnt < lim) begin
          avm_waitrequest = 1'b1;
          cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = (avm_address == BASE) ? id_data : ts_data;
          cnt = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_read"},     avm_read, 0);
    checkOutput({tag, "_addr"},     avm_address, BASE);
    checkOutput({tag, "_busy"},     busy, 0);
    checkOutput({tag, "_done"},     done, 0);
    checkOutput({tag, "_id_ok"},    id_ok, 0);
    checkOutput({tag, "_ts_ok"},    ts_ok, 0);
    checkOutput({tag, "_timeout"},  timeout, 0);
    checkOutput({tag, "_id_value"}, id_value, 0);
    checkOutput({tag, "_ts_value"}, ts_value, 0);
  endtask

  // Runs one check (by start pulse, or by auto start right after reset release) and
  // compares timing, bus activity and status against values derived from the stall counts.
  task automatic applyStimulus(input bit use_start, input bit pester);
    int n, lat, rises, high, jumps, idle_rd, done_pulses;
    int exp_lat, exp_reads, exp_high;
    bit id_to, ts_to, exp_id_ok, exp_ts_ok, prev_rd;
    logic [31:0] prev_ad;
    logic [31:0] addrs[$];
    n = 0; lat = -1; rises = 0; high = 0; jumps = 0; idle_rd = 0; done_pulses = 0;
    prev_rd = 1'b0; prev_ad = '0;

    id_to = (stall_id >= TO);
    ts_to = !id_to && (stall_ts >= TO);
    if (id_to) begin
      exp_lat = TO + 2; exp_reads = 1; exp_high = TO;
    end else if (ts_to) begin
      exp_lat = stall_id + TO + 4; exp_reads = 2; exp_high = stall_id + 1 + TO;
    end else begin
      exp_lat = stall_id + stall_ts + 5; exp_reads = 2; exp_high = stall_id + stall_ts + 2;
    end
    exp_id_ok = !id_to && (id_data == EXP_ID);
    exp_ts_ok = !id_to && !ts_to && (ts_data == EXP_TS);
    if (!id_to) exp_id_value = id_data;
    if (!id_to && !ts_to) exp_ts_value = ts_data;

    if (use_start) start = 1'b1;
    while (n < exp_lat + 12) begin
      @(negedge clock);
      n++;
      start = 1'b0;
      if (pester && lat < 0 && n % 2 == 0) start = 1'b1;
      if (avm_read) begin
        high++;
        if (!prev_rd) begin
          rises++;
          addrs.push_back(avm_address);
        end else if (avm_address != prev_ad) begin
          jumps++;
        end
        if (!busy) idle_rd++;
      end
      prev_rd = avm_read;
      prev_ad = avm_address;
      if (done) begin
        done_pulses++;
        if (lat < 0) begin
          lat = n;
          checkOutput("busy_at_done", busy, 1);
          if (pester) start = 1'b1;
        end
      end
      if (lat > 0 && n == lat + 1) begin
        checkOutput("done_width", done, 0);
        checkOutput("busy_after_done", busy, 0);
      end
    end

    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("done_pulses", 64'(done_pulses), 1);
    checkOutput("read_count", 64'(rises), 64'(exp_reads));
    checkOutput("read_cycles", 64'(high), 64'(exp_high));
    checkOutput("addr_stable", 64'(jumps), 0);
    checkOutput("idle_read", 64'(idle_rd), 0);
    if (addrs.size() > 0) checkOutput("addr_id", addrs[0], BASE);
    if (addrs.size() > 1) checkOutput("addr_ts", addrs[1], BASE + 32'd4);
    checkOutput("id_ok", id_ok, exp_id_ok);
    checkOutput("ts_ok", ts_ok, exp_ts_ok);
    checkOutput("timeout", timeout, id_to || ts_to);
    checkOutput("id_value", id_value, exp_id_value);
    checkOutput("ts_value", ts_value, exp_ts_value);
  endtask

  initial begin : main
    int k;
    $display("[TB] sysid_check_master bench starting");
    repeat (2) @(negedge clock);
    checkResetValues("reset");

    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0);

    stall_id = 3; stall_ts = 3;
    applyStimulus(1'b1, 1'b0);

    stall_id = 0; stall_ts = 0; ts_data = 32'h534C_DDA4;
    applyStimulus(1'b1, 1'b0);

    stall_id = STUCK; ts_data = EXP_TS;
    applyStimulus(1'b1, 1'b0);

    stall_id = 2; stall_ts = STUCK; id_data = 32'h0000_0001;
    applyStimulus(1'b1, 1'b0);

    stall_id = TO - 1; stall_ts = TO - 1; id_data = EXP_ID;
    applyStimulus(1'b1, 1'b0);

    stall_id = 3; stall_ts = 3;
    applyStimulus(1'b1, 1'b1);

    // Reset while the timestamp read is stalled, then let the auto check rerun.
    stall_id = 0; stall_ts = 20;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      k++;
    end while (!(avm_read && avm_address == BASE + 32'd4 && avm_waitrequest) && k < 20);
    checkOutput("ts_stall_reached", 64'(k < 20), 1);
    #2 reset_n = 1'b0;
    #1 checkResetValues("mid_reset");
    exp_id_value = '0;
    exp_ts_value = '0;
    @(negedge clock);
    checkOutput("held_reset_read", avm_read, 0);
    stall_ts = 1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      stall_id = $urandom_range(0, 10);
      stall_ts = $urandom_range(0, 10);
      id_data  = $urandom_range(0, 1) ? EXP_ID : $urandom;
      case ($urandom_range(0, 3))
        0, 1:    ts_data = EXP_TS;
        2:       ts_data = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
        default: ts_data = $urandom;
      endcase
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
